// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and RV32I access sequencer for a single-port,
// registered-read, word-write data memory. Sub-word stores are read-modify-write.
module dmem_arbiter #(
  parameter int unsigned AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [31:0]   i_wdata0,
  input  logic [31:0]   i_wdata1,
  input  logic [2:0]    i_size0,
  input  logic [2:0]    i_size1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic [31:0]   o_rdata,
  output logic          o_err,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   size_q, size_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [SW-1:0]   sel_size;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0; size[1] marks a word.
  function automatic logic misaligned(input logic [SW-1:0] sz, input logic [1:0] off);
    return (sz[1:0] == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
  endfunction

  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w,
                                             input logic [1:0] off,
                                             input logic [SW-1:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    if (sz[1])
      return w;
    else if (sz[0])
      return sz[2] ? {16'b0, h} : {{16{h[15]}}, h};
    else
      return sz[2] ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] w,
                                                input logic [DW-1:0] d,
                                                input logic [1:0] off,
                                                input logic [SW-1:0] sz);
    logic [DW-1:0] m;
    m = w;
    if (sz[0]) begin
      if (off[1]) m[31:16] = d[15:0];
      else        m[15:0]  = d[15:0];
    end else begin
      case (off)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end
    return m;
  endfunction

  // On a tie the port not served last wins; a lone requester always wins.
  assign win       = (i_req0 && i_req1) ? ~last_q : i_req1;
  assign sel_we    = win ? i_we1    : i_we0;
  assign sel_addr  = win ? i_addr1  : i_addr0;
  assign sel_wdata = win ? i_wdata1 : i_wdata0;
  assign sel_size  = win ? i_size1  : i_size0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state and next registered outputs; outputs are set one state early.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          port_d      = win;
          we_d        = sel_we;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          size_d      = sel_size;
          rdata_d     = '0;
          err_d       = 1'b0;
          mem_addr_d  = {sel_addr[AW-1:2], 2'b00};
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_we && sel_size[1] && (sel_addr[1:0] == 2'b00);
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (misaligned(size_q, addr_q[1:0])) begin
          err_d   = 1'b1;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = S_DONE;
        end else if (we_q && size_q[1]) begin
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!we_q) begin
          rdata_d = load_ext(i_mem_rdata, addr_q[1:0], size_q);
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = S_DONE;
        end else begin
          mem_wdata_d = store_merge(i_mem_rdata, wdata_q, addr_q[1:0], size_q);
          mem_we_d    = 1'b1;
          state_d     = S_WB;
        end
      end
      S_WB: begin
        ack0_d  = ~port_q;
        ack1_d  = port_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = port_q;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ack0      = ack0_q;
  assign o_ack1      = ack1_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural registered-read memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  size0, size1;
  logic        ack0, ack1, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [7:0]  wemask;
    logic [31:0] wrdata;
    logic [31:0] wraddr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_size0(size0), .i_size1(size1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_err(err),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:2]];
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size);
    if (port) begin
      we1 = we; addr1 = addr; wdata1 = wdata; size1 = size; req1 = 1'b1;
    end else begin
      we0 = we; addr0 = addr; wdata0 = wdata; size0 = size; req0 = 1'b1;
    end
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns the same way.
  task automatic access(input string tag, input logic port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input logic [31:0] erd,
                        input logic eerr, input int elat, input logic [7:0] emask,
                        input logic [31:0] ewr);
    exp_t e;
    logic [7:0]  mask;
    logic [31:0] wr, wa;
    logic [1:0]  acks;
    logic [31:0] got_rd;
    logic        got_err;
    int          lat;
    e.port = port; e.rdata = erd; e.err = eerr; e.lat = elat;
    e.wemask = emask; e.wrdata = ewr; e.wraddr = {addr[31:2], 2'b00};
    sb.push_back(e);
    drive(port, we, addr, wdata, size);
    mask = '0; wr = '0; wa = '0; lat = 99; acks = '0; got_rd = '0; got_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mem_we) begin
        if (n < 8) mask[n] = 1'b1;
        wr = mem_wdata; wa = mem_addr;
      end
      if (ack0 || ack1) begin
        lat = n; acks = {ack1, ack0}; got_rd = rdata; got_err = err;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    check({tag, "_acks"}, 32'(acks), e.port ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, got_rd, e.rdata);
    check({tag, "_err"}, 32'(got_err), 32'(e.err));
    check({tag, "_wemask"}, 32'(mask), 32'(e.wemask));
    if (e.wemask != 8'h0) begin
      check({tag, "_wdata"}, wr, e.wrdata);
      check({tag, "_waddr"}, wa, e.wraddr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int cyc, prev, cnt;
    logic bad;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; size0 = 0; size1 = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    access("sw",   0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0, 2, 8'b0000_0010, 32'hDEADBEEF);
    access("lb",   0, 0, 32'h13, 32'h0,        3'b000, 32'hFFFFFFDE, 0, 3, 8'h0, 32'h0);
    access("lbu",  0, 0, 32'h13, 32'h0,        3'b100, 32'h000000DE, 0, 3, 8'h0, 32'h0);
    access("lhu",  0, 0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 0, 3, 8'h0, 32'h0);
    access("sb",   1, 1, 32'h11, 32'h00000055, 3'b000, 32'h0,        0, 4, 8'b0000_1000, 32'hDEAD55EF);
    access("lw",   1, 0, 32'h10, 32'h0,        3'b010, 32'hDEAD55EF, 0, 3, 8'h0, 32'h0);
    access("lh",   0, 0, 32'h12, 32'h0,        3'b001, 32'hFFFFDEAD, 0, 3, 8'h0, 32'h0);
    access("lb0",  1, 0, 32'h10, 32'h0,        3'b000, 32'hFFFFFFEF, 0, 3, 8'h0, 32'h0);
    access("sh",   0, 1, 32'h12, 32'hFFFF1234, 3'b001, 32'h0,        0, 4, 8'b0000_1000, 32'h123455EF);
    access("lw2",  0, 0, 32'h10, 32'h0,        3'b010, 32'h123455EF, 0, 3, 8'h0, 32'h0);
    access("lh_mis", 0, 0, 32'h11, 32'h0,      3'b001, 32'h0,        1, 2, 8'h0, 32'h0);
    access("lw_mis", 1, 0, 32'h12, 32'h0,      3'b010, 32'h0,        1, 2, 8'h0, 32'h0);
    access("sw_mis", 0, 1, 32'h11, 32'h11111111, 3'b010, 32'h0,      1, 2, 8'h0, 32'h0);
    access("lw_chk", 0, 0, 32'h10, 32'h0,      3'b010, 32'h123455EF, 0, 3, 8'h0, 32'h0);
    access("sw1",  1, 1, 32'h14, 32'hCAFEF00D, 3'b010, 32'h0,        0, 2, 8'b0000_0010, 32'hCAFEF00D);

    // Both ports stream word loads: grants alternate starting with port 0.
    for (int k = 0; k < 4; k++) begin
      e.port = k[0]; e.rdata = k[0] ? 32'hCAFEF00D : 32'h123455EF; e.err = 0;
      e.lat = 0; e.wemask = 0; e.wrdata = 0; e.wraddr = 0;
      sb.push_back(e);
    end
    drive(0, 0, 32'h10, 32'h0, 3'b010);
    drive(1, 0, 32'h14, 32'h0, 3'b010);
    cyc = 0; prev = -1; cnt = 0;
    while (cnt < 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack0 || ack1) begin
        e = sb.pop_front();
        check("alt_acks", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
        check("alt_rdata", rdata, e.rdata);
        check("alt_err", 32'(err), 0);
        check("alt_spacing", 32'(cyc - prev), (prev < 0) ? 32'd4 : 32'd4);
        prev = cyc;
        cnt++;
        if (cnt == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("alt_count", 32'(cnt), 4);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Reset while a byte store sits in WAIT: nothing must be written or acked.
    drive(0, 1, 32'h18, 32'h00000055, 3'b000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_mem_we", 32'(mem_we), 0);
    check("rstw_acks", 32'({ack1, ack0}), 0);
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_we || ack0 || ack1) bad = 1'b1;
    end
    req0 = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_we || ack0 || ack1) bad = 1'b1;
    end
    check("rstw_quiet", 32'(bad), 0);
    check("rstw_mem", mem[6], 32'h0);
    access("post_lw", 0, 0, 32'h18, 32'h0,        3'b010, 32'h0, 0, 3, 8'h0, 32'h0);
    access("post_sb", 0, 1, 32'h1A, 32'h000000A5, 3'b000, 32'h0, 0, 4, 8'b0000_1000, 32'h00A50000);
    access("post_lbu", 1, 0, 32'h1A, 32'h0,       3'b100, 32'h000000A5, 0, 3, 8'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port, word-wide data memory, which has a registered read and a word-only write enable. It shares the memory between the core load/store unit (port 0) and the debug/loader port (port 1) using round-robin arbitration. It handles RV32I access sizes: loads are extracted and sign- or zero-extended, and byte/halfword stores are performed as read-modify-write.

## Interface
- AW, 32, address width of requester and memory address buses
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req0 / i_req1  in  1  access request, held until matching ack
- i_we0 / i_we1  in  1  1 = store, 0 = load
- i_addr0 / i_addr1  in  AW  byte address
- i_wdata0 / i_wdata1  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- i_size0 / i_size1  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use [1:0])
- o_ack0 / o_ack1  out  1  one-cycle completion pulse for that port
- o_rdata  out  32  load result, valid while any ack is high
- o_err  out  1  misaligned access, valid while any ack is high
- o_mem_we  out  1  memory word write enable
- o_mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- o_mem_wdata  out  32  memory write data
- i_mem_rdata  in  32  memory read data, valid one cycle after address presented

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB, DONE.
- IDLE: if any req, pick winner, latch its we/addr/wdata/size and port id → ISSUE. No req → stay.
- Arbitration: one requester wins. If both request, the port not served last wins. The last-served bit resets to 1, so port 0 wins the first tie.
- ISSUE: o_mem_addr = latched aligned address.
  - Misaligned (H with addr[0]=1, W with addr[1:0]≠0): no memory write, err=1 → DONE.
  - Word store: o_mem_we=1, o_mem_wdata=latched data → DONE.
  - Otherwise o_mem_we=0 → WAIT.
- WAIT: i_mem_rdata valid.
  - Load: extract lane (byte lane addr[1:0], half lane addr[1]), sign-extend for B/H, zero-extend for BU/HU, register into o_rdata → DONE.
  - Sub-word store: merge wdata into the selected lane of rdata, register merged word → WB.
- WB: o_mem_we=1, o_mem_addr held, o_mem_wdata=merged word → DONE.
- DONE: assert served port's o_ack for exactly one cycle with o_rdata/o_err; update last-served → IDLE.
- o_rdata=0 for stores and errors. o_mem_we is high only in ISSUE (word store) or WB.
- Requester holds req and fields stable until ack. A req still high in the IDLE cycle after ack is a new request, so back-to-back is legal.
- Reset: async to IDLE. All outputs 0, latched request cleared, last-served=1. Reset mid-access aborts without any later write; a port must re-request.

## Timing
- Cycle 0 is the first IDLE cycle with req high.
- Ack lands in cycle 2 for a word store or an error, cycle 3 for a load, and cycle 4 for a sub-word store.
- Throughput: one access per latency+1 cycles (IDLE turnaround).
- Losing port waits; it is served at the next IDLE if still requesting. No starvation with two ports.
- Memory write occurs on the rising edge ending ISSUE (word store) or WB (sub-word store). The read of the same word completes at the edge ending ISSUE, before the WB write.

## Test plan
- Reset, then port 0 SW 0xDEADBEEF to addr 0x10 → o_mem_we high in cycle 1 with addr 0x10; ack0 in cycle 2; o_err=0.
- Port 0 LB from 0x13 after that store → o_rdata=0xFFFFFFDE. Port 0 LBU 0x13 → 0x000000DE. Port 0 LHU 0x10 → 0x0000BEEF.
- Port 1 SB 0x55 to 0x11 → read-then-write sequence, WB writes 0xDEAD55EF; ack1 in cycle 4; a following LW 0x10 returns 0xDEAD55EF.
- Both ports request continuously with word loads → acks alternate 0,1,0,1 starting with port 0; each ack spaced 4 cycles apart.
- LH from 0x11 and LW from 0x12 → ack in cycle 2, o_err=1, o_rdata=0, o_mem_we never high.
- Assert i_rst during WAIT of an SB → o_mem_we stays 0, no ack, FSM in IDLE; after release, a new request completes normally.
